// File: rtl/rv32_pkg.sv
// RV32I opcode map, instruction field positions and
// the register-usage decoder shared by the read stage.
package rv32_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam int RS1_MSB = 19;
  localparam int RS1_LSB = 15;
  localparam int RS2_MSB = 24;
  localparam int RS2_LSB = 20;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 7;

  typedef struct packed {
    logic uses_rs1;
    logic uses_rs2;
    logic writes_rd;
  } dec_t;

  function automatic dec_t decode(
    input logic [6:0] opc,
    input logic [4:0] rd
  );
    dec_t d;
    d = '0;
    unique case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL: begin
        d.writes_rd = 1'b1;
      end
      OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
        d.uses_rs1  = 1'b1;
        d.writes_rd = 1'b1;
      end
      OPC_BRANCH, OPC_STORE: begin
        d.uses_rs1 = 1'b1;
        d.uses_rs2 = 1'b1;
      end
      OPC_OP: begin
        d.uses_rs1  = 1'b1;
        d.uses_rs2  = 1'b1;
        d.writes_rd = 1'b1;
      end
      default: d = '0;
    endcase
    // x0 is hardwired, so it never becomes a pending write
    d.writes_rd = d.writes_rd & (rd != 5'd0);
    return d;
  endfunction

endpackage

// File: rtl/rd_fifo.sv
// In-order FIFO of pending destination registers.
// Every entry is exposed for parallel hazard compare.
module rd_fifo
  import rv32_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1),
  parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic [4:0]            push_rd,
  input  logic                  pop,
  output logic [DEPTH-1:0][4:0] ent_rd,
  output logic [DEPTH-1:0]      ent_vld,
  output logic [PW-1:0]         head_ptr,
  output logic [CW-1:0]         occupancy,
  output logic                  full
);

  logic [DEPTH-1:0][4:0] rd_q;
  logic [DEPTH-1:0]      vld_q;
  logic [PW-1:0]         head_q;
  logic [PW-1:0]         tail_q;
  logic [CW-1:0]         occ_q;

  // Pointers, valid bits and occupancy; flush empties the queue
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      vld_q  <= '0;
    end else begin
      if (pop) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= head_q + PW'(1);
      end
      if (push) begin
        vld_q[tail_q] <= 1'b1;
        tail_q        <= tail_q + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   occ_q <= occ_q + CW'(1);
        2'b01:   occ_q <= occ_q - CW'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  // Register numbers need no reset; the valid bits qualify them
  always_ff @(posedge clk) begin
    if (push && !rst && !flush) begin
      rd_q[tail_q] <= push_rd;
    end
  end

  assign ent_rd    = rd_q;
  assign ent_vld   = vld_q;
  assign head_ptr  = head_q;
  assign occupancy = occ_q;
  assign full      = (occ_q == CW'(DEPTH));

endmodule

// File: rtl/rd_hazard_scoreboard.sv
// Read-stage issue control: RAW hazard detection against
// in-flight writers, with same-cycle writeback bypass.
module rd_hazard_scoreboard
  import rv32_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   IR,
  input  logic          v_in,
  input  logic          r_in,
  input  logic          v_wb,
  input  logic [4:0]    WB_address,
  input  logic          flush,
  output logic          stall,
  output logic          issue,
  output logic          hazard_rs1,
  output logic          hazard_rs2,
  output logic [CW-1:0] occupancy,
  output logic          full,
  output logic          wb_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][4:0] ent_rd;
  logic [DEPTH-1:0]      ent_vld;
  logic [PW-1:0]         head_ptr;
  logic [4:0]            head_rd;
  logic                  head_vld;
  logic [4:0]            rs1;
  logic [4:0]            rs2;
  logic [4:0]            rd;
  dec_t                  dec;
  logic                  bypass;
  logic                  hit1;
  logic                  hit2;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  err_set;
  logic                  wb_err_q;
  logic [9:0]            unused_ir;

  assign rs1 = IR[RS1_MSB:RS1_LSB];
  assign rs2 = IR[RS2_MSB:RS2_LSB];
  assign rd  = IR[RD_MSB:RD_LSB];
  assign dec = decode(IR[6:0], rd);
  assign unused_ir = {IR[31:25], IR[14:12]};

  assign head_rd  = ent_rd[head_ptr];
  assign head_vld = ent_vld[head_ptr];
  assign empty    = (occupancy == '0);

  // Writeback data is forwarded, so the retiring head stops blocking
  assign bypass = v_wb & head_vld & (head_rd == WB_address);

  // Parallel compare of both sources against every live entry
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && !(bypass && head_ptr == PW'(i))) begin
        if (ent_rd[i] == rs1) hit1 = 1'b1;
        if (ent_rd[i] == rs2) hit2 = 1'b1;
      end
    end
  end

  assign hazard_rs1 = v_in & dec.uses_rs1 & (rs1 != 5'd0) & hit1;
  assign hazard_rs2 = v_in & dec.uses_rs2 & (rs2 != 5'd0) & hit2;
  assign stall = v_in & (hazard_rs1 | hazard_rs2 | full);
  assign issue = v_in & r_in & ~stall & ~flush;

  assign push    = issue & dec.writes_rd;
  assign pop     = v_wb & ~empty;
  assign err_set = v_wb & (empty | (head_rd != WB_address));

  rd_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW),
    .PW    (PW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_rd   (rd),
    .pop       (pop),
    .ent_rd    (ent_rd),
    .ent_vld   (ent_vld),
    .head_ptr  (head_ptr),
    .occupancy (occupancy),
    .full      (full)
  );

  // Sticky writeback-ordering error; only reset clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_err_q <= 1'b0;
    end else if (err_set) begin
      wb_err_q <= 1'b1;
    end
  end

  assign wb_err = wb_err_q;

endmodule

// File: tb/tb_rd_hazard_scoreboard.sv
// Scenario bench for rd_hazard_scoreboard (DEPTH=4).
// Expected outputs are queued with each stimulus row.
module tb_rd_hazard_scoreboard;

  logic        clk;
  logic        rst;
  logic [31:0] IR;
  logic        v_in;
  logic        r_in;
  logic        v_wb;
  logic [4:0]  WB_address;
  logic        flush;
  logic        stall;
  logic        issue;
  logic        hazard_rs1;
  logic        hazard_rs2;
  logic [2:0]  occupancy;
  logic        full;
  logic        wb_err;

  typedef struct packed {
    logic [31:0] ir;
    logic        v;
    logic        r;
    logic        wb;
    logic [4:0]  wba;
    logic        fl;
    logic        rs;
  } stim_t;

  typedef struct packed {
    logic       stall;
    logic       issue;
    logic       h1;
    logic       h2;
    logic [2:0] occ;
    logic       full;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;

  rd_hazard_scoreboard #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .IR         (IR),
    .v_in       (v_in),
    .r_in       (r_in),
    .v_wb       (v_wb),
    .WB_address (WB_address),
    .flush      (flush),
    .stall      (stall),
    .issue      (issue),
    .hazard_rs1 (hazard_rs1),
    .hazard_rs2 (hazard_rs2),
    .occupancy  (occupancy),
    .full       (full),
    .wb_err     (wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] addi(
    input logic [4:0] rd, input logic [4:0] rs1);
    return {12'd1, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] add(
    input logic [4:0] rd, input logic [4:0] rs1,
    input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic stim_t S(
    input logic [31:0] ir, input logic v, input logic r,
    input logic wb, input logic [4:0] wba,
    input logic fl, input logic rs);
    return '{ir, v, r, wb, wba, fl, rs};
  endfunction

  function automatic exp_t E(
    input logic st, input logic is, input logic h1,
    input logic h2, input logic [2:0] occ,
    input logic fu, input logic er);
    return '{st, is, h1, h2, occ, fu, er};
  endfunction

  function automatic exp_t observe();
    return '{stall, issue, hazard_rs1, hazard_rs2,
             occupancy, full, wb_err};
  endfunction

  task automatic apply(input stim_t s);
    IR         = s.ir;
    v_in       = s.v;
    r_in       = s.r;
    v_wb       = s.wb;
    WB_address = s.wba;
    flush      = s.fl;
    rst        = s.rs;
  endtask

  localparam logic [31:0] IDLE = 32'h0;

  task automatic test_reset();
    stim_t sq[$];
    exp_t  eq[$];
    exp_t  o;
    exp_t  e;
    apply(S(IDLE, 0, 0, 0, 0, 0, 1));
    @(posedge clk); @(posedge clk); #1;
    sq.push_back(S(IDLE, 0, 0, 0, 0, 0, 0));
    eq.push_back(E(0, 0, 0, 0, 0, 0, 0));
    sq.push_back(S(IDLE, 0, 1, 0, 0, 0, 0));
    eq.push_back(E(0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < sq.size(); i++) begin
      apply(sq[i]);
      exp_q.push_back(eq[i]);
      #1;
      o = observe();
      e = exp_q.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL reset[%0d]: got %b required %b", i, o, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_raw();
    stim_t sq[$];
    exp_t  eq[$];
    exp_t  o;
    exp_t  e;
    sq.push_back(S(addi(5, 0), 1, 1, 0, 0, 0, 0));
    eq.push_back(E(0, 1, 0, 0, 0, 0, 0));
    sq.push_back(S(add(6, 5, 5), 1, 1, 0, 0, 0, 0));
    eq.push_back(E(1, 0, 1, 1, 1, 0, 0));
    sq.push_back(S(add(6, 5, 5), 1, 1, 1, 5, 0, 0));
    eq.push_back(E(0, 1, 0, 0, 1, 0, 0));
    sq.push_back(S(IDLE, 0, 0, 1, 6, 0, 0));
    eq.push_back(E(0, 0, 0, 0, 1, 0, 0));
    sq.push_back(S(add(7, 6, 5), 1, 0, 0, 0, 0, 0));
    eq.push_back(E(0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < sq.size(); i++) begin
      apply(sq[i]);
      exp_q.push_back(eq[i]);
      #1;
      o = observe();
      e = exp_q.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL raw[%0d]: got %b required %b", i, o, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_x0();
    stim_t sq[$];
    exp_t  eq[$];
    exp_t  o;
    exp_t  e;
    sq.push_back(S(addi(5, 0), 1, 0, 0, 0, 0, 0));
    eq.push_back(E(0, 0, 0, 0, 0, 0, 0));
    sq.push_back(S(32'h00000013, 1, 1, 0, 0, 0, 0));
    eq.push_back(E(0, 1, 0, 0, 0, 0, 0));
    sq.push_back(S(32'h00002023, 1, 1, 0, 0, 0, 0));
    eq.push_back(E(0, 1, 0, 0, 0, 0, 0));
    sq.push_back(S(add(1, 0, 0), 1, 1, 0, 0, 0, 0));
    eq.push_back(E(0, 1, 0, 0, 0, 0, 0));
    sq.push_back(S(IDLE, 0, 0, 1, 1, 0, 0));
    eq.push_back(E(0, 0, 0, 0, 1, 0, 0));
    sq.push_back(S(IDLE, 0, 0, 0, 0, 0, 0));
    eq.push_back(E(0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < sq.size(); i++) begin
      apply(sq[i]);
      exp_q.push_back(eq[i]);
      #1;
      o = observe();
      e = exp_q.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL x0[%0d]: got %b required %b", i, o, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_full();
    stim_t sq[$];
    exp_t  eq[$];
    exp_t  o;
    exp_t  e;
    for (int k = 0; k < 4; k++) begin
      sq.push_back(S(addi(5'(k + 1), 0), 1, 1, 0, 0, 0, 0));
      eq.push_back(E(0, 1, 0, 0, 3'(k), 0, 0));
    end
    sq.push_back(S(addi(7, 0), 1, 1, 0, 0, 0, 0));
    eq.push_back(E(1, 0, 0, 0, 4, 1, 0));
    sq.push_back(S(addi(7, 0), 1, 1, 1, 1, 0, 0));
    eq.push_back(E(1, 0, 0, 0, 4, 1, 0));
    sq.push_back(S(addi(7, 0), 1, 1, 0, 0, 0, 0));
    eq.push_back(E(0, 1, 0, 0, 3, 0, 0));
    sq.push_back(S(IDLE, 0, 0, 1, 2, 0, 0));
    eq.push_back(E(0, 0, 0, 0, 4, 1, 0));
    sq.push_back(S(IDLE, 0, 0, 1, 3, 0, 0));
    eq.push_back(E(0, 0, 0, 0, 3, 0, 0));
    sq.push_back(S(IDLE, 0, 0, 1, 4, 0, 0));
    eq.push_back(E(0, 0, 0, 0, 2, 0, 0));
    sq.push_back(S(IDLE, 0, 0, 1, 7, 0, 0));
    eq.push_back(E(0, 0, 0, 0, 1, 0, 0));
    sq.push_back(S(IDLE, 0, 0, 0, 0, 0, 0));
    eq.push_back(E(0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < sq.size(); i++) begin
      apply(sq[i]);
      exp_q.push_back(eq[i]);
      #1;
      o = observe();
      e = exp_q.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL full[%0d]: got %b required %b", i, o, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    stim_t sq[$];
    exp_t  eq[$];
    exp_t  o;
    exp_t  e;
    sq.push_back(S(addi(8, 0), 1, 1, 0, 0, 0, 0));
    eq.push_back(E(0, 1, 0, 0, 0, 0, 0));
    sq.push_back(S(addi(9, 0), 1, 1, 0, 0, 0, 0));
    eq.push_back(E(0, 1, 0, 0, 1, 0, 0));
    for (int k = 0; k < 10; k++) begin
      sq.push_back(S(addi(5'(10 + k), 0), 1, 1, 1, 5'(8 + k), 0, 0));
      eq.push_back(E(0, 1, 0, 0, 2, 0, 0));
    end
    sq.push_back(S(add(1, 18, 19), 1, 1, 1, 18, 0, 0));
    eq.push_back(E(1, 0, 0, 1, 2, 0, 0));
    sq.push_back(S(IDLE, 0, 0, 1, 19, 0, 0));
    eq.push_back(E(0, 0, 0, 0, 1, 0, 0));
    sq.push_back(S(IDLE, 0, 0, 0, 0, 0, 0));
    eq.push_back(E(0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < sq.size(); i++) begin
      apply(sq[i]);
      exp_q.push_back(eq[i]);
      #1;
      o = observe();
      e = exp_q.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL b2b[%0d]: got %b required %b", i, o, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush();
    stim_t sq[$];
    exp_t  eq[$];
    exp_t  o;
    exp_t  e;
    for (int k = 0; k < 3; k++) begin
      sq.push_back(S(addi(5'(k + 1), 0), 1, 1, 0, 0, 0, 0));
      eq.push_back(E(0, 1, 0, 0, 3'(k), 0, 0));
    end
    sq.push_back(S(add(4, 3, 1), 1, 1, 0, 0, 0, 0));
    eq.push_back(E(1, 0, 1, 1, 3, 0, 0));
    sq.push_back(S(add(4, 3, 1), 1, 1, 0, 0, 1, 0));
    eq.push_back(E(1, 0, 1, 1, 3, 0, 0));
    sq.push_back(S(add(4, 3, 1), 1, 1, 0, 0, 0, 0));
    eq.push_back(E(0, 1, 0, 0, 0, 0, 0));
    sq.push_back(S(IDLE, 0, 0, 1, 4, 0, 0));
    eq.push_back(E(0, 0, 0, 0, 1, 0, 0));
    sq.push_back(S(IDLE, 0, 0, 0, 0, 0, 0));
    eq.push_back(E(0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < sq.size(); i++) begin
      apply(sq[i]);
      exp_q.push_back(eq[i]);
      #1;
      o = observe();
      e = exp_q.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL flush[%0d]: got %b required %b", i, o, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_err_reset();
    stim_t sq[$];
    exp_t  eq[$];
    exp_t  o;
    exp_t  e;
    sq.push_back(S(addi(5, 0), 1, 1, 0, 0, 0, 0));
    eq.push_back(E(0, 1, 0, 0, 0, 0, 0));
    sq.push_back(S(IDLE, 0, 0, 1, 7, 0, 0));
    eq.push_back(E(0, 0, 0, 0, 1, 0, 0));
    sq.push_back(S(IDLE, 0, 0, 0, 0, 0, 0));
    eq.push_back(E(0, 0, 0, 0, 0, 0, 1));
    sq.push_back(S(addi(9, 0), 1, 1, 0, 0, 0, 0));
    eq.push_back(E(0, 1, 0, 0, 0, 0, 1));
    sq.push_back(S(IDLE, 0, 0, 0, 0, 0, 1));
    eq.push_back(E(0, 0, 0, 0, 1, 0, 1));
    sq.push_back(S(IDLE, 0, 0, 0, 0, 0, 0));
    eq.push_back(E(0, 0, 0, 0, 0, 0, 0));
    sq.push_back(S(IDLE, 0, 0, 1, 3, 0, 0));
    eq.push_back(E(0, 0, 0, 0, 0, 0, 0));
    sq.push_back(S(IDLE, 0, 0, 0, 0, 0, 0));
    eq.push_back(E(0, 0, 0, 0, 0, 0, 1));
    sq.push_back(S(addi(3, 0), 1, 1, 0, 0, 0, 0));
    eq.push_back(E(0, 1, 0, 0, 0, 0, 1));
    sq.push_back(S(IDLE, 0, 0, 1, 3, 0, 0));
    eq.push_back(E(0, 0, 0, 0, 1, 0, 1));
    sq.push_back(S(IDLE, 0, 0, 0, 0, 1, 0));
    eq.push_back(E(0, 0, 0, 0, 0, 0, 1));
    sq.push_back(S(IDLE, 0, 0, 0, 0, 0, 0));
    eq.push_back(E(0, 0, 0, 0, 0, 0, 1));
    for (int i = 0; i < sq.size(); i++) begin
      apply(sq[i]);
      exp_q.push_back(eq[i]);
      #1;
      o = observe();
      e = exp_q.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL err_rst[%0d]: got %b required %b", i, o, e);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    apply(S(IDLE, 0, 0, 0, 0, 0, 1));
    test_reset();
    test_raw();
    test_x0();
    test_full();
    test_back_to_back();
    test_flush();
    test_err_reset();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
